// File: rtl/spim_rxtx_if.sv
// -----------------------------------------------------------------------------
// spim_rxtx_if -- bundle of the request, configuration, status and serial-pin
// signals of the spim_rxtx SPI master.
//
// Parameters
//   NUM_CS : number of active-low chip-select lines (1..8)
//   DIV_W  : width of clk_div
//
// Modports
//   master : the host side. It issues start/release_cs, supplies configuration
//            and transmit data, and drives miso toward the block. It observes
//            data_rx, rdy and the serial outputs.
//   slave  : the spim_rxtx core.
//
// Optional build macro
//   SPIM_LOOPBACK_EN : adds a 'loopback' request line. When it is 1, the core
//                      samples its own mosi instead of miso.
// -----------------------------------------------------------------------------
interface spim_rxtx_if #(
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8
);
  // Request and configuration, host -> core
  logic              start;
  logic              release_cs;
  logic              cpol;
  logic              cpha;
  logic              hold;
  logic              msbytefirst;
  logic [1:0]        datawidth;
  logic [DIV_W-1:0]  clk_div;
  logic [2:0]        cs_sel;
  logic [31:0]       data_tx;
`ifdef SPIM_LOOPBACK_EN
  logic              loopback;
`endif

  // Status and received data, core -> host
  logic [31:0]       data_rx;
  logic              rdy;

  // Serial pins
  logic              miso;
  logic              mosi;
  logic              sclk;
  logic [NUM_CS-1:0] cs_n;

  modport master (
    output start, release_cs, cpol, cpha, hold, msbytefirst,
    output datawidth, clk_div, cs_sel, data_tx, miso,
`ifdef SPIM_LOOPBACK_EN
    output loopback,
`endif
    input  data_rx, rdy, mosi, sclk, cs_n
  );

  modport slave (
    input  start, release_cs, cpol, cpha, hold, msbytefirst,
    input  datawidth, clk_div, cs_sel, data_tx, miso,
`ifdef SPIM_LOOPBACK_EN
    input  loopback,
`endif
    output data_rx, rdy, mosi, sclk, cs_n
  );
endinterface

// File: rtl/spim_rxtx.sv
// -----------------------------------------------------------------------------
// spim_rxtx -- single-clock SPI master. It sends 8/16/24/32-bit words with
// selectable clock polarity and phase, byte order and sclk divider, and can
// keep a chip select asserted across back-to-back transfers.
//
// Parameters
//   NUM_CS : number of chip selects (1..8)
//   DIV_W  : width of clk_div; sclk half-period = clk_div+1 clk cycles
//
// Ports
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : spim_rxtx_if.slave
//           inputs  : start, release_cs, cpol, cpha, hold, msbytefirst,
//                     datawidth (00=8,10=16,11=24,01=32), clk_div, cs_sel,
//                     data_tx, miso (and loopback, when built with it)
//           outputs : data_rx, rdy, mosi, sclk, cs_n
//
// Optional build macro
//   SPIM_LOOPBACK_EN : when defined, bus.loopback=1 routes mosi to the
//                      receive shifter and ignores miso.
//
// Sequence: IDLE -> [LEAD] -> XFER -> [TAIL] -> IDLE. Each phase step lasts
// clk_div+1 cycles. LEAD is skipped when the requested chip select is already
// held. TAIL is skipped when the transfer asks to keep its chip select held.
// -----------------------------------------------------------------------------
module spim_rxtx #(
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  spim_rxtx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TAIL
  } state_t;

  state_t state, state_nxt;

  // Configuration latched at acceptance
  logic              cpol_q;
  logic              cpha_q;
  logic              hold_q;
  logic              msbf_q;
  logic [1:0]        dw_q;
  logic [DIV_W-1:0]  div_q;
  logic [2:0]        cs_q;

  // Chip-select holding between transfers
  logic              held_vld;
  logic [2:0]        held_idx;

  // Timing
  logic [DIV_W-1:0]  cnt;
  logic [5:0]        edge_cnt;
  logic              tick;
  logic              last_edge;
  logic [5:0]        n_q;
  logic [5:0]        last_idx;

  // Datapath
  logic [31:0]       tx_sh;
  logic [31:0]       rx_sh;
  logic [31:0]       rx_next;
  logic [31:0]       rx_final;
  logic [31:0]       data_rx_q;
  logic              mosi_q;
  logic              sclk_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              miso_int;

  // Input-side decode at acceptance
  logic              accept;
  logic              same_cs;
  logic [5:0]        n_in;
  logic [31:0]       tx_ord;
  logic [31:0]       tx_first;

  // FSM outputs
  logic              rdy;
  logic              sample;
  logic              advance;
  logic              done;

  // Transfer width in bits for a datawidth code.
  function automatic logic [5:0] width_of(input logic [1:0] dw);
    case (dw)
      2'b00:   return 6'd8;
      2'b10:   return 6'd16;
      2'b11:   return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  // Reverse the order of the low nb bytes. Bytes above nb stay zero. This is
  // used both to turn an LSByte-first word into serial order and to undo it.
  function automatic logic [31:0] byte_rev(input logic [31:0] w, input logic [2:0] nb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(nb)) r[8*i +: 8] = w[8*(int'(nb)-1-i) +: 8];
    end
    return r;
  endfunction

  // Active-low one-hot chip select. An index of NUM_CS or more selects none.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [2:0] idx);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (idx == 3'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

`ifdef SPIM_LOOPBACK_EN
  assign miso_int = bus.loopback ? mosi_q : bus.miso;
`else
  assign miso_int = bus.miso;
`endif

  assign accept    = (state == ST_IDLE) && bus.start;
  assign same_cs   = held_vld && (bus.cs_sel == held_idx);
  assign n_in      = width_of(bus.datawidth);
  assign tx_ord    = bus.msbytefirst ? bus.data_tx : byte_rev(bus.data_tx, n_in[5:3]);
  // Left-align so the first serial bit is always at bit 31.
  assign tx_first  = tx_ord << (6'd32 - n_in);

  assign tick      = (cnt == div_q);
  assign n_q       = width_of(dw_q);
  // 2N-1 in 6-bit arithmetic. For N=32, 2N wraps to 0 and gives 63.
  assign last_idx  = (n_q << 1) - 6'd1;
  assign last_edge = (edge_cnt == last_idx);

  assign rx_next   = sample ? {rx_sh[30:0], miso_int} : rx_sh;
  assign rx_final  = msbf_q ? rx_next : byte_rev(rx_next, n_q[5:3]);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: flops use non-blocking assignments so that every register in the
  // same clock edge sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default first so that no path leaves the signal
    // unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = same_cs ? ST_XFER : ST_LEAD;
      ST_LEAD: if (tick) state_nxt = ST_XFER;
      ST_XFER: if (tick && last_edge) state_nxt = hold_q ? ST_IDLE : ST_TAIL;
      ST_TAIL: if (tick) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // Even XFER steps end in a leading sclk edge and odd steps in a trailing one.
  // cpha=0 samples on leading edges and shifts on trailing edges. cpha=1 does
  // the reverse.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdy     = 1'b0;
    sample  = 1'b0;
    advance = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: rdy = 1'b1;
      ST_XFER: begin
        if (tick) begin
          sample  = (edge_cnt[0] == cpha_q);
          advance = (edge_cnt[0] != cpha_q) && !last_edge;
          done    = last_edge && hold_q;
        end
      end
      ST_TAIL: done = tick;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Half-period and edge counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      edge_cnt <= '0;
    end else begin
      if (state == ST_IDLE) cnt <= '0;
      else                  cnt <= tick ? '0 : cnt + DIV_W'(1);

      if (state != ST_XFER)            edge_cnt <= '0;
      else if (tick && last_edge)      edge_cnt <= '0;
      else if (tick)                   edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration, shifters, serial pins and chip selects
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      hold_q    <= 1'b0;
      msbf_q    <= 1'b0;
      dw_q      <= 2'b00;
      div_q     <= '0;
      cs_q      <= '0;
      held_vld  <= 1'b0;
      held_idx  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      data_rx_q <= '0;
      mosi_q    <= 1'b1;
      sclk_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          // sclk follows the live cpol input while idle.
          sclk_q <= bus.cpol;
          mosi_q <= 1'b1;
          if (bus.start) begin
            cpol_q <= bus.cpol;
            cpha_q <= bus.cpha;
            hold_q <= bus.hold;
            msbf_q <= bus.msbytefirst;
            dw_q   <= bus.datawidth;
            div_q  <= bus.clk_div;
            cs_q   <= bus.cs_sel;
            rx_sh  <= '0;
            if (bus.cpha) begin
              tx_sh <= tx_first;
            end else begin
              // With cpha=0 the first bit must already be valid when sclk
              // starts, so put it on mosi right away.
              mosi_q <= tx_first[31];
              tx_sh  <= tx_first << 1;
            end
            // A new chip select replaces any held one in the same cycle.
            if (!same_cs) begin
              cs_n_q   <= cs_decode(bus.cs_sel);
              held_vld <= 1'b0;
            end
          end else if (bus.release_cs) begin
            cs_n_q   <= '1;
            held_vld <= 1'b0;
          end
        end
        ST_XFER: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            if (advance) begin
              mosi_q <= tx_sh[31];
              tx_sh  <= tx_sh << 1;
            end
            if (sample) rx_sh <= rx_next;
            if (last_edge) begin
              mosi_q   <= 1'b1;
              held_vld <= hold_q;
              held_idx <= cs_q;
            end
          end
        end
        ST_TAIL: begin
          if (tick) cs_n_q <= '1;
        end
        default: ;
      endcase

      if (done) data_rx_q <= rx_final;
    end
  end

  assign bus.rdy     = rdy;
  assign bus.mosi    = mosi_q;
  assign bus.sclk    = sclk_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.data_rx = data_rx_q;

endmodule

// File: tb/tb_spim_rxtx.sv
// -----------------------------------------------------------------------------
// tb_spim_rxtx -- directed self-checking bench for spim_rxtx (NUM_CS=4).
// Each transfer pushes its expected outcome to a scoreboard queue when start is
// driven. The entry is popped and compared once rdy returns high. A negedge
// monitor measures the rdy-low length, sclk rising edges, the mosi bit at each
// rising edge, and the OR/AND of cs_n over the busy window.
// -----------------------------------------------------------------------------
module tb_spim_rxtx;

  localparam int NUM_CS = 4;
  localparam int DIV_W  = 8;

  typedef struct {
    int          id;
    logic [31:0] rx;
    int          cycles;
    int          rises;
    logic [31:0] mosi;
    logic [3:0]  cs;
  } exp_t;

  logic clk;
  logic rst_n;
  logic loop_ext;
  logic miso_drv;

  int vectors;
  int miscompares;
  int xfer_id;

  exp_t sb[$];

  // Monitor results
  int          low_cnt;
  int          rise_cnt;
  logic [31:0] mosi_cap;
  logic [3:0]  cs_or;
  logic [3:0]  cs_and;
  logic        rdy_d;
  logic        sclk_d;
  logic        mosi_d;

  spim_rxtx_if #(.NUM_CS(NUM_CS), .DIV_W(DIV_W)) bus ();

  spim_rxtx #(.NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The serial device model: either echoes mosi or returns a fixed level.
  assign bus.miso = loop_ext ? bus.mosi : miso_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt  <= 0;
      rise_cnt <= 0;
      mosi_cap <= '0;
      cs_or    <= '0;
      cs_and   <= '1;
      rdy_d    <= 1'b1;
      sclk_d   <= 1'b0;
      mosi_d   <= 1'b1;
    end else begin
      rdy_d  <= bus.rdy;
      sclk_d <= bus.sclk;
      mosi_d <= bus.mosi;
      if (!bus.rdy) begin
        if (rdy_d) begin
          low_cnt  <= 1;
          rise_cnt <= 0;
          mosi_cap <= '0;
          cs_or    <= bus.cs_n;
          cs_and   <= bus.cs_n;
        end else begin
          low_cnt <= low_cnt + 1;
          cs_or   <= cs_or | bus.cs_n;
          cs_and  <= cs_and & bus.cs_n;
          if (bus.sclk && !sclk_d) begin
            rise_cnt <= rise_cnt + 1;
            mosi_cap <= {mosi_cap[30:0], mosi_d};
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for rdy to rise, then pop and compare one scoreboard entry.
  task automatic wait_done();
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.rdy !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("rdy_rise", {31'b0, bus.rdy}, 32'd1);
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check($sformatf("x%0d_data_rx", e.id), bus.data_rx, e.rx);
      check($sformatf("x%0d_rdy_low", e.id), 32'(low_cnt), 32'(e.cycles));
      check($sformatf("x%0d_sclk_rises", e.id), 32'(rise_cnt), 32'(e.rises));
      check($sformatf("x%0d_mosi", e.id), mosi_cap, e.mosi);
      check($sformatf("x%0d_cs_or", e.id), {28'b0, cs_or}, {28'b0, e.cs});
      check($sformatf("x%0d_cs_and", e.id), {28'b0, cs_and}, {28'b0, e.cs});
    end
  endtask

  // Drive configuration one cycle ahead of start, pulse start, push expectation.
  task automatic launch(input logic cpol_i, input logic cpha_i, input logic hold_i,
                        input logic msbf_i, input logic [1:0] dw_i, input logic [7:0] div_i,
                        input logic [2:0] cs_i, input logic [31:0] tx_i, input int n_i,
                        input int lead_i, input int tail_i, input logic [31:0] exp_rx,
                        input logic [31:0] exp_mosi, input logic [3:0] exp_cs);
    exp_t e;
    @(negedge clk);
    bus.cpol        = cpol_i;
    bus.cpha        = cpha_i;
    bus.hold        = hold_i;
    bus.msbytefirst = msbf_i;
    bus.datawidth   = dw_i;
    bus.clk_div     = div_i;
    bus.cs_sel      = cs_i;
    bus.data_tx     = tx_i;
    @(negedge clk);
    bus.start = 1'b1;
    xfer_id++;
    e.id     = xfer_id;
    e.rx     = exp_rx;
    e.cycles = (int'(div_i) + 1) * (2 * n_i + lead_i + tail_i);
    e.rises  = n_i;
    e.mosi   = exp_mosi;
    e.cs     = exp_cs;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    xfer_id     = 0;
    rst_n       = 1'b0;
    loop_ext    = 1'b0;
    miso_drv    = 1'b0;
    bus.start       = 1'b0;
    bus.release_cs  = 1'b0;
    bus.cpol        = 1'b0;
    bus.cpha        = 1'b0;
    bus.hold        = 1'b0;
    bus.msbytefirst = 1'b1;
    bus.datawidth   = 2'b00;
    bus.clk_div     = '0;
    bus.cs_sel      = '0;
    bus.data_tx     = '0;
`ifdef SPIM_LOOPBACK_EN
    bus.loopback    = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'b0, bus.rdy}, 32'd1);
    check("rst_cs_n", {28'b0, bus.cs_n}, 32'hF);
    check("rst_sclk", {31'b0, bus.sclk}, 32'd0);
    check("rst_mosi", {31'b0, bus.mosi}, 32'd1);
    check("rst_data_rx", bus.data_rx, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, div=1, 8-bit, echo: 36 busy cycles, 8 rising edges.
    loop_ext = 1'b1;
    launch(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd1, 3'd0, 32'h000000A5, 8, 1, 1,
           32'h000000A5, 32'h000000A5, 4'b1110);
    wait_done();

    // Mode 3, div=0, 32-bit, LSByte first, echo.
    launch(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 8'd0, 3'd0, 32'h11223344, 32, 1, 1,
           32'h11223344, 32'h44332211, 4'b1110);
    wait_done();

    // 24-bit, MSByte first, miso tied high.
    loop_ext = 1'b0;
    miso_drv = 1'b1;
    launch(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'd2, 3'd1, 32'hFFABCDEF, 24, 1, 1,
           32'h00FFFFFF, 32'h00ABCDEF, 4'b1101);
    wait_done();

    // Start while busy is ignored; reset mid-transfer aborts it.
    miso_drv = 1'b0;
    loop_ext = 1'b1;
    @(negedge clk);
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.hold = 1'b0; bus.msbytefirst = 1'b1;
    bus.datawidth = 2'b00; bus.clk_div = 8'd1; bus.cs_sel = 3'd0; bus.data_tx = 32'h5A;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start  = 1'b1;
    bus.cs_sel = 3'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start_rdy", {31'b0, bus.rdy}, 32'd0);
    check("busy_start_cs_n", {28'b0, bus.cs_n}, 32'hE);
    rst_n = 1'b0;
    #1;
    check("abort_rdy", {31'b0, bus.rdy}, 32'd1);
    check("abort_cs_n", {28'b0, bus.cs_n}, 32'hF);
    check("abort_data_rx", bus.data_rx, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_rdy", {31'b0, bus.rdy}, 32'd1);
    check("post_rst_cs_n", {28'b0, bus.cs_n}, 32'hF);
    check("post_rst_data_rx", bus.data_rx, 32'd0);
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    // Held chip select: two 16-bit transfers on cs 2, div=3, then release.
    launch(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 8'd3, 3'd2, 32'h0000BEEF, 16, 1, 0,
           32'h0000BEEF, 32'h0000BEEF, 4'b1011);
    wait_done();
    check("hold1_cs_n", {28'b0, bus.cs_n}, 32'hB);
    loop_ext = 1'b0;
    miso_drv = 1'b0;
    launch(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 8'd3, 3'd2, 32'h00001234, 16, 0, 0,
           32'h00000000, 32'h00001234, 4'b1011);
    wait_done();
    check("hold2_cs_n", {28'b0, bus.cs_n}, 32'hB);
    bus.release_cs = 1'b1;
    @(negedge clk);
    bus.release_cs = 1'b0;
    check("release_cs_n", {28'b0, bus.cs_n}, 32'hF);

    // Out-of-range chip select: full timing, no line asserted.
    launch(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0, 3'd7, 32'h0000003C, 8, 1, 1,
           32'h00000000, 32'h0000003C, 4'b1111);
    wait_done();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spim_rxtx.md
SPIM_RXTX -- requirements
Module: spim_rxtx

Interface
REQ-001 SHALL have parameter NUM_CS, default 1, range 1..8: number of chip-select outputs.
REQ-002 SHALL have parameter DIV_W, default 8: width of clk_div.
REQ-003 SHALL have ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle transfer request
- release_cs  in  1  single-cycle request to deassert a held chip select
- cpol  in  1  idle sclk level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- hold  in  1  keep chip select asserted after this transfer
- msbytefirst  in  1  send MSByte first, else LSByte first; MSbit of each byte always first
- datawidth  in  2  00=8, 10=16, 11=24, 01=32 bits
- clk_div  in  DIV_W  sclk half-period = clk_div+1 clk cycles
- cs_sel  in  3  chip-select index
- miso  in  1  serial data in
- data_tx  in  32  transmit word, right-aligned
- data_rx  out  32  received word, right-aligned, zero-extended
- rdy  out  1  idle, ready for start
- mosi  out  1  serial data out
- sclk  out  1  serial clock
- cs_n  out  NUM_CS  chip selects, active-low

Function
REQ-004 start SHALL be accepted only while rdy=1; otherwise ignored; release_cs SHALL be ignored while rdy=0.
REQ-005 On acceptance, cpol, cpha, hold, msbytefirst, datawidth, clk_div, cs_sel, data_tx SHALL be latched; rdy SHALL be 0 from the next cycle.
REQ-006 State machine: IDLE, LEAD, XFER, TAIL; each LEAD/TAIL/XFER phase step lasts one half-period (clk_div+1 cycles).
REQ-007 IDLE->LEAD on start when no chip select is held or cs_sel differs from the held one; IDLE->XFER on start when cs_sel equals the held index.
REQ-008 LEAD: cs_n[cs_sel] SHALL be 0, sclk=cpol, one half-period, then XFER.
REQ-009 XFER SHALL last 2N half-periods, N = transfer width; sclk toggles at each half-period boundary, starting at cpol.
REQ-010 cpha=0: first bit SHALL be on mosi at XFER entry; miso sampled at leading edges; mosi advances at trailing edges.
REQ-011 cpha=1: mosi advances at leading edges; miso sampled at trailing edges.
REQ-012 XFER->TAIL when hold=0; XFER->IDLE with cs kept asserted when hold=1.
REQ-013 TAIL: one half-period, sclk=cpol, cs held; cs_n SHALL be all 1 on TAIL->IDLE.
REQ-014 rdy SHALL return to 1 exactly (clk_div+1)*(2N+L+T) cycles after it fell, L=1 if LEAD ran else 0, T=1 if TAIL ran else 0.
REQ-015 Byte order: msbytefirst=1 sends data_tx[N-1] first; msbytefirst=0 sends byte 0 first, each byte MSbit first; received bits SHALL land in the same bit positions that were sent.
REQ-016 data_rx SHALL update only when rdy rises and hold its value until the next completion; bits above N SHALL be 0.
REQ-017 In IDLE: mosi=1, sclk=cpol as sampled each IDLE cycle.
REQ-018 cs_sel >= NUM_CS SHALL run a full transfer with all cs_n=1.
REQ-019 release_cs in IDLE SHALL set all cs_n=1 on the next cycle; if coincident with start, start SHALL win and release_cs SHALL be ignored.
REQ-020 Accepted start with a different cs_sel while holding SHALL deassert the held cs_n on the next cycle, before LEAD.

Reset
REQ-021 While rst_n=0: rdy=1, cs_n all 1, sclk=0, mosi=1, data_rx=0, state IDLE, no held chip select.
REQ-022 Reset mid-transfer SHALL abort immediately, with no data_rx update.

Configuration
REQ-023 With SPIM_LOOPBACK_EN defined, input loopback SHALL exist and, when 1, internal miso SHALL equal mosi, external miso ignored.
REQ-024 Without SPIM_LOOPBACK_EN, no loopback port SHALL exist and miso SHALL always be used.

Verification
REQ-025 The bench SHALL cover:
- mode 0, div=1, 8-bit, data_tx=0xA5, miso=mosi loop -> data_rx=0x000000A5, rdy low 36 cycles, 8 rising sclk edges.
- mode 3, div=0, 32-bit, msbytefirst=0, data_tx=0x11223344 -> mosi order 0x44,0x33,0x22,0x11, data_rx=0x11223344 under loopback.
- 24-bit, msbytefirst=1, data_tx=0xFFABCDEF, miso tied 1 -> mosi 0xABCDEF, data_rx=0x00FFFFFF.
- hold=1 two 16-bit transfers cs_sel=2, div=3, then release_cs -> cs_n[2] low throughout, second rdy-low 128 cycles, cs_n all 1 one cycle after release.
- start at cycle 10 of 8-bit transfer, then rst_n low -> start ignored; after reset rdy=1, cs_n all 1, data_rx=0.
- cs_sel=7 with NUM_CS=4 -> full transfer timing, cs_n stays 4'b1111.
